// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one single-port synchronous SRAM (1-cycle read latency) between
//   NUM_REQ requesters using registered round-robin arbitration with
//   bounded bursts. Every release is followed by one idle cycle.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | no owner; picks next requester upward from rr_ptr
//   S_GRANT| owner holds gnt; one access per cycle while req[owner] high
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req/req_we          per-requester request level and write enable
//   req_addr/req_din    flattened per-requester address / write data
//   gnt                 registered one-hot grant
//   rvalid/rdata        one-hot read-return strobe and read data
//   mem_cs/we/addr/din  SRAM control, muxed from the registered owner
//   mem_dout            SRAM read data (valid one cycle after a read)
module sram_port_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_din,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          mem_cs,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_din,
  input  logic [DATA_WIDTH-1:0]         mem_dout
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t          state;
  logic [OW-1:0]   owner;
  logic [OW-1:0]   rr_ptr;
  logic [OW-1:0]   winner;
  logic [OW-1:0]   next_ptr;
  logic [BW-1:0]   burst_cnt;
  logic            grant_any;
  logic            last_beat;

  // First requester at or above rr_ptr, wrapping modulo NUM_REQ.
  function automatic logic [OW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                            input logic [OW-1:0]      p);
    logic [OW-1:0] w;
    logic          found;
    int            idx;
    w     = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(p) + i) % NUM_REQ;
      if (!found && r[idx]) begin
        w     = OW'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  always_comb begin
    winner    = rr_pick(req, rr_ptr);
    next_ptr  = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + OW'(1);
    grant_any = |gnt;
    // The access performed this cycle is the MAX_BURST-th of the ownership.
    last_beat = (burst_cnt == BW'(MAX_BURST - 1));
  end

  // Memory mux driven only from the registered owner; with no grant every
  // memory-side signal is held at zero so non-owners never leak through.
  always_comb begin
    mem_cs   = gnt[owner] & req[owner];
    mem_we   = mem_cs & req_we[owner];
    mem_addr = grant_any ? req_addr[owner*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    mem_din  = grant_any ? req_din[owner*DATA_WIDTH +: DATA_WIDTH]  : '0;
  end

  assign rdata = mem_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      gnt       <= '0;
      rvalid    <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      owner     <= '0;
    end else begin
      // Read return is tagged with the owner of the access cycle, so it
      // still fires when the grant is released on the same edge.
      rvalid <= (mem_cs && !mem_we) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << owner)
                                    : '0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            owner     <= winner;
            gnt       <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
            burst_cnt <= '0;
            state     <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (req[owner]) begin
            burst_cnt <= burst_cnt + BW'(1);
          end
          if (!req[owner] || last_beat) begin
            gnt    <= '0;
            rr_ptr <= next_ptr;
            state  <= S_IDLE;
          end
        end
        default: begin
          gnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int MB = 8;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_din;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rvalid;
  logic [DW-1:0]   rdata;
  logic            mem_cs;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_din;
  logic [DW-1:0]   mem_dout;

  sram_port_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_din(req_din), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM attached to the arbiter's memory port.
  logic [DW-1:0] sram [16];
  initial begin
    for (int i = 0; i < 16; i++) sram[i] = 8'(i * 37 + 11);
    sram[5]  = 8'hA7;
    mem_dout = '0;
    forever begin
      @(posedge clk);
      if (mem_cs) begin
        if (mem_we) sram[mem_addr] = mem_din;
        else        mem_dout       = sram[mem_addr];
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: ownership described as who owns the port, how many
  // accesses it has made, and whose turn is next.
  logic [DW-1:0] ref_mem [16];
  int            m_busy, m_owner, m_cnt, m_ptr;
  int            m_rv, m_rv_owner;
  logic [DW-1:0] m_rv_data;

  function automatic logic [AW-1:0] addr_of(input int i);
    return req_addr[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] din_of(input int i);
    return req_din[i*DW +: DW];
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
    m_rv = 0; m_rv_owner = 0; m_rv_data = '0;
  endtask

  task automatic model_check();
    int acc;
    acc = (m_busy != 0) && req[m_owner];
    check("gnt",      gnt,      m_busy ? (1 << m_owner) : 0);
    check("mem_cs",   mem_cs,   acc);
    check("mem_we",   mem_we,   acc && req_we[m_owner]);
    check("mem_addr", mem_addr, m_busy ? addr_of(m_owner) : 0);
    check("mem_din",  mem_din,  m_busy ? din_of(m_owner) : 0);
    check("rvalid",   rvalid,   m_rv ? (1 << m_rv_owner) : 0);
    if (m_rv != 0) check("rdata", rdata, m_rv_data);
  endtask

  task automatic model_update();
    int acc, wr, found;
    logic [AW-1:0] a;
    acc = (m_busy != 0) && req[m_owner];
    wr  = acc && req_we[m_owner];
    a   = addr_of(m_owner);
    m_rv       = acc && !wr;
    m_rv_owner = m_owner;
    m_rv_data  = ref_mem[a];
    if (wr != 0) ref_mem[a] = din_of(m_owner);
    if (m_busy == 0) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        if (found == 0 && req[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          found   = 1;
        end
      end
      if (found != 0) begin
        m_busy = 1;
        m_cnt  = 0;
      end
    end else begin
      if (req[m_owner]) m_cnt++;
      if (!req[m_owner] || m_cnt == MB) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
      end
    end
  endtask

  // One clock cycle: check mid-cycle, advance model on the edge, then
  // return 1 time unit after the edge for the next stimulus.
  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    if (rst) model_reset();
    else     model_update();
    #1;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(3) == 0) req[i] = ~req[i];
      req_we[i] = 1'($urandom_range(1));
    end
    req_addr = 12'($urandom);
    req_din  = 24'($urandom);
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'(i * 37 + 11);
    ref_mem[5] = 8'hA7;
    rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_din = '0;
    model_reset();
    step();
    step();
    rst = 1'b0;

    // Idle with no requests.
    repeat (10) step();

    // Single read by requester 1 from address 5.
    req[1] = 1'b1; req_we[1] = 1'b0; req_addr[1*AW +: AW] = 4'h5;
    step();
    step();
    check("single_rvalid", rvalid, 3'b010);
    check("single_rdata",  rdata,  8'hA7);
    req = '0;
    repeat (3) step();

    // Everyone requesting: rotation with bursts capped at MB.
    req = 3'b111; req_we = '0; req_addr = 12'h7A3;
    repeat (40) step();
    req = '0;
    repeat (3) step();

    // Requester 0 alone: repeated capped bursts.
    req = 3'b001;
    repeat (20) step();
    req = '0;
    repeat (3) step();

    // Requester 2 writes 0x3C to address 9 then reads it back, with
    // requester 0 requesting in the background.
    req = 3'b100; req_we = 3'b100;
    req_addr = '0; req_addr[2*AW +: AW] = 4'h9; req_addr[0 +: AW] = 4'h1;
    req_din  = '0; req_din[2*DW +: DW] = 8'h3C;
    guard = 0;
    while (!(m_busy != 0 && m_owner == 2) && guard < 10) begin
      step();
      guard++;
    end
    check("wr_owner_reached", guard < 10, 1);
    req[0] = 1'b1;
    step();
    req_we[2] = 1'b0;
    step();
    check("rb_rvalid", rvalid, 3'b100);
    check("rb_rdata",  rdata,  8'h3C);
    req[2] = 1'b0;
    repeat (25) step();
    req = '0;
    repeat (3) step();

    // Reset while requester 1 is mid-burst reading.
    req = 3'b010; req_we = '0; req_addr = 12'h050;
    guard = 0;
    while (!(m_busy != 0 && m_owner == 1) && guard < 10) begin
      step();
      guard++;
    end
    check("rd_owner_reached", guard < 10, 1);
    step();
    rst = 1'b1;
    #1;
    check("rst_gnt",    gnt,    0);
    check("rst_rvalid", rvalid, 0);
    check("rst_mem_cs", mem_cs, 0);
    model_reset();
    step();
    rst = 1'b0;
    step();
    check("post_rst_gnt", gnt, 3'b010);
    req = '0;
    repeat (3) step();

    // Randomised traffic.
    repeat (2000) begin
      rand_inputs();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
